// File: rtl/dm_lsu_pkg.sv
// lsu_pkg: shared definitions for the dm_lsu load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state enum
//   - helpers: active-low byte-lane write mask, store-data replication,
//     request error check
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        LOAD_DATA = 2'd2
    } lsu_state_e;

    // Active-low bit-write mask: 0 marks the bits that get written.
    function automatic logic [31:0] lsu_lane_mask(input logic [2:0] f3,
                                                  input logic [1:0] lo);
        logic [31:0] mask;
        case (f3)
            F3_B:    mask = ~(32'h0000_00FF << {lo, 3'b000});
            F3_H:    mask = ~(32'h0000_FFFF << {lo[1], 4'b0000});
            F3_W:    mask = 32'h0000_0000;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

    // Right-justified store data copied into every lane it could land in.
    function automatic logic [31:0] lsu_store_data(input logic [2:0]  f3,
                                                   input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{d[7:0]}};
            F3_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Misaligned access or funct3 that is illegal for the direction.
    function automatic logic lsu_is_err(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = lo[0];
            F3_W:    err = (lo != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Bus interfaces for dm_lsu.
//   dm_lsu_if      : CPU request/response channel.
//                    master = CPU, slave = LSU.
//   dm_lsu_sram_if : data-memory SRAM port (all strobes active low).
//                    master = LSU, slave = SRAM wrapper.
interface dm_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface dm_lsu_sram_if #(parameter int ADDR_W = 14);
    logic              sram_ceb;
    logic              sram_web;
    logic [31:0]       sram_bweb;
    logic [ADDR_W-1:0] sram_a;
    logic [31:0]       sram_di;
    logic [31:0]       sram_do;

    modport master (
        output sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
        input  sram_do
    );

    modport slave (
        input  sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
        output sram_do
    );
endinterface

// File: rtl/dm_lsu_load_align.sv
// lsu_load_align: combinational load-data extraction.
//   i_word    : 32-bit word read from memory
//   i_addr_lo : byte offset within the word
//   i_funct3  : load funct3 (B, H, W, BU, HU)
//   o_result  : selected lane, sign- or zero-extended
// Kept free of state so the CPU forwarding path can reuse it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'h00_0000, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'h0000, w_half};
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit between the CPU memory stage and the data SRAM.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   cpu  : request/response channel (dm_lsu_if.slave)
//   sram : SRAM port (dm_lsu_sram_if.master), driven only in ACCESS
// One request per handshake. Errors answer in the cycle after accept,
// stores two cycles after, loads three cycles after.
//
// State     | meaning
// IDLE      | ready for a request; error responses issued from here
// ACCESS    | SRAM enabled from the request registers (read or write)
// LOAD_DATA | sram_do valid; aligned load result captured
module dm_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dm_lsu_if.slave       cpu,
    dm_lsu_sram_if.master sram
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W+1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_req_err;
    logic [DATA_W-1:0] w_load_result;
    logic              w_unused_addr;

    // Upper address bits wrap away by design.
    assign w_unused_addr = ^cpu.req_addr[31:ADDR_W+2];

    assign w_accept  = cpu.req_valid & cpu.req_ready;
    assign w_req_err = lsu_is_err(cpu.req_we, cpu.req_funct3, cpu.req_addr[1:0]);

    assign cpu.rsp_valid = r_rsp_valid;
    assign cpu.rsp_rdata = r_rsp_rdata;
    assign cpu.rsp_err   = r_rsp_err;

    lsu_load_align u_load_align (
        .i_word    (sram.sram_do),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_result  (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        cpu.req_ready  = 1'b0;
        sram.sram_ceb  = 1'b1;
        sram.sram_web  = 1'b1;
        sram.sram_bweb = 32'hFFFF_FFFF;
        sram.sram_a    = '0;
        sram.sram_di   = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                cpu.req_ready = 1'b1;
                if (cpu.req_valid && !w_req_err) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // The SRAM samples on the same edge that applies reset, so
                // the strobes must already be gated in the reset cycle.
                if (!rst) begin
                    sram.sram_ceb = 1'b0;
                    sram.sram_web = ~r_we;
                    sram.sram_a   = r_addr[ADDR_W+1:2];
                    if (r_we) begin
                        sram.sram_bweb = lsu_lane_mask(r_funct3, r_addr[1:0]);
                        sram.sram_di   = lsu_store_data(r_funct3, r_wdata);
                    end
                end
                w_state_nxt = r_we ? IDLE : LOAD_DATA;
            end
            LOAD_DATA: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we     <= cpu.req_we;
                        r_funct3 <= cpu.req_funct3;
                        r_addr   <= cpu.req_addr[ADDR_W+1:0];
                        r_wdata  <= cpu.req_wdata;
                        if (w_req_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                LOAD_DATA: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= w_load_result;
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
Load/store unit between the CPU memory stage and the data-memory SRAM_wrapper.
- Accepts one RV32I load or store per handshake.
- Checks alignment, builds the active-low bit-write mask and the replicated store data, and drives the SRAM port.
- Absorbs the SRAM's one-cycle read latency.
- Returns aligned, sign- or zero-extended load data on a single-cycle response pulse.

Parameters:
ADDR_W, 14, SRAM word-address width; the block drives req_addr[ADDR_W+1:2].
DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  1  CPU request valid
req_ready  out  1  block can accept a request; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned access or illegal funct3; valid with rsp_valid
sram_ceb  out  1  chip enable, active low
sram_web  out  1  write enable, active low
sram_bweb  out  32  per-bit write enable, active low
sram_a  out  ADDR_W  word address
sram_di  out  32  write data
sram_do  in  32  read data; valid the cycle after the read cycle

Behaviour:
- Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0. Request registers cleared.
- SRAM idle values: sram_ceb=1, sram_web=1, sram_bweb=32'hFFFFFFFF, sram_a=0, sram_di=0.
- Reset mid-operation aborts the access. No SRAM write or response may occur in or after the reset cycle.
- FSM states: IDLE, ACCESS, LOAD_DATA.
- IDLE:
  - req_ready=1; the handshake is req_valid & req_ready.
  - On accept, register we, funct3, addr and wdata, and evaluate err.
  - err=1: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; stay IDLE; no SRAM access.
  - Otherwise go to ACCESS.
- ACCESS, all SRAM outputs driven from the request registers:
  - sram_ceb=0, sram_a=addr[ADDR_W+1:2], sram_web=~we.
  - Store: sram_bweb=lane mask, sram_di=replicated data. Next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0; go to IDLE.
  - Load: sram_bweb=all ones; go to LOAD_DATA.
- LOAD_DATA:
  - Capture sram_do, select lane by addr[1:0], and sign- or zero-extend per funct3.
  - Next cycle rsp_valid=1 with rsp_rdata; go to IDLE.
- Latency from the accept cycle N:
  - Error: response in N+1.
  - Store: SRAM write at the end of N+1; response in N+2.
  - Load: SRAM read in N+1, data in N+2; response in N+3.
- rsp_valid has no backpressure; the CPU stalls on req_ready. A new request may be accepted in the same cycle rsp_valid is high (state is IDLE).
- Lane mask, sram_bweb (active low):
  - SB: bits [8k+7:8k]=0 for k=addr[1:0], all other bits 1.
  - SH: bits [16h+15:16h]=0 for h=addr[1].
  - SW: all bits 0.
- Replicated store data, sram_di:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extraction:
  - LB/LBU: byte k, sign- or zero-extended.
  - LH/LHU: half h, sign- or zero-extended.
  - LW: full word.
- err conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 not in {000, 001, 010}.
- req_addr bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- rsp_rdata and rsp_err hold their last values while rsp_valid=0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_e {IDLE, ACCESS, LOAD_DATA}
  - function or typedef for the byte-lane mask
- One combinational sub-module, lsu_load_align (word, addr[1:0], funct3 -> 32-bit result), reusable by the CPU's forwarding logic.

Test Plan:
- SW addr 0x0000_0010, data 0xDEADBEEF -> in N+1: sram_a=4, sram_web=0, sram_bweb=0; in N+2: rsp_valid=1, rsp_err=0. Then LW 0x10 -> rsp_rdata=0xDEADBEEF in N+3.
- SB addr 0x13, data 0x0000_00A5 onto word 0x11223344 -> sram_bweb=0x00FFFFFF, sram_di=0xA5A5A5A5. LW 0x10 then returns 0xA5223344; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- SH addr 0x22, data 0x8001 -> sram_bweb=0x0000FFFF. LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- LW addr 0x06, LH addr 0x05, and store funct3=100 -> each gives rsp_valid with rsp_err=1 in N+1, sram_ceb stays 1, memory unchanged.
- Back-to-back: assert a second req_valid in the store's response cycle -> accepted that cycle (req_ready=1); req_ready=0 in ACCESS and LOAD_DATA.
- Assert rst during ACCESS of a store -> no write occurs (memory unchanged), no rsp_valid, and state is IDLE the next cycle.
